// File: rtl/branch_sequencer.sv
// branch_sequencer: T3..T6 control sequence for the br instruction family
// (brzr/brnz/brpl/brmi). The condition flip-flop is sampled in T3, PC+C is
// formed in T4/T5, and PC is reloaded in T6 only when the branch is taken.
// Optional feature macro: BRANCH_STATS_EN adds saturating taken/not-taken
// counters (taken_cnt, not_taken_cnt) of width CNT_W.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   IDLE   | waiting for start from the decoder
//   T3     | Ra onto bus via IR field, evaluate condition
//   T4     | PC onto bus, latch into Y
//   T5     | sign-extended C onto bus, ALU add, latch into Z
//   T6     | Zlow onto bus, load PC if taken
//   DONE   | one-cycle completion pulse, hold ignored

module branch_sequencer #(
    parameter logic [4:0] BR_OPCODE = 5'b10010
`ifdef BRANCH_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic        hold,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        gra,
    output logic        r_out,
    output logic        con_in,
    output logic        pc_out,
    output logic        y_in,
    output logic        c_out,
    output logic        alu_add,
    output logic        z_in,
    output logic        zlo_out,
    output logic        pc_in,
    output logic        busy,
    output logic        done,
    output logic        taken,
    output logic        bad_op
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] not_taken_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T3   = 3'd1,
        S_T4   = 3'd2,
        S_T5   = 3'd3,
        S_T6   = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t state_q, state_d;
    logic   taken_q, taken_d;
    logic   bad_op_q, bad_op_d;
    logic   op_ok;
    logic   unused_ir;

    assign op_ok     = (ir[31:27] == BR_OPCODE);
    assign unused_ir = ^ir[26:0];

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] not_taken_cnt_q, not_taken_cnt_d;
`endif

    // Next-state, branch decision and statistics update.
    always_comb begin
        state_d  = state_q;
        taken_d  = taken_q;
        bad_op_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (op_ok) begin
                        state_d = S_T3;
                        taken_d = 1'b0;
                    end else begin
                        bad_op_d = 1'b1;
                    end
                end
            end
            S_T3: begin
                if (!hold) begin
                    state_d = S_T4;
                    taken_d = con_ff;
                end
            end
            S_T4:   if (!hold) state_d = S_T5;
            S_T5:   if (!hold) state_d = S_T6;
            S_T6:   if (!hold) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef BRANCH_STATS_EN
        taken_cnt_d     = taken_cnt_q;
        not_taken_cnt_d = not_taken_cnt_q;
        if (state_q == S_T6 && !hold) begin
            if (taken_q) begin
                if (taken_cnt_q != {CNT_W{1'b1}})
                    taken_cnt_d = taken_cnt_q + 1'b1;
            end else begin
                if (not_taken_cnt_q != {CNT_W{1'b1}})
                    not_taken_cnt_d = not_taken_cnt_q + 1'b1;
            end
        end
`endif
    end

    // FSM state and registered outputs; clr overrides everything.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= S_IDLE;
            taken_q  <= 1'b0;
            bad_op_q <= 1'b0;
`ifdef BRANCH_STATS_EN
            taken_cnt_q     <= '0;
            not_taken_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            taken_q  <= taken_d;
            bad_op_q <= bad_op_d;
`ifdef BRANCH_STATS_EN
            taken_cnt_q     <= taken_cnt_d;
            not_taken_cnt_q <= not_taken_cnt_d;
`endif
        end
    end

    // Strobes follow the current state and drop immediately under hold.
    assign gra     = (state_q == S_T3) && !hold;
    assign r_out   = (state_q == S_T3) && !hold;
    assign con_in  = (state_q == S_T3) && !hold;
    assign pc_out  = (state_q == S_T4) && !hold;
    assign y_in    = (state_q == S_T4) && !hold;
    assign c_out   = (state_q == S_T5) && !hold;
    assign alu_add = (state_q == S_T5) && !hold;
    assign z_in    = (state_q == S_T5) && !hold;
    assign zlo_out = (state_q == S_T6) && !hold;
    assign pc_in   = (state_q == S_T6) && !hold && taken_q;

    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign taken   = taken_q;
    assign bad_op  = bad_op_q;

`ifdef BRANCH_STATS_EN
    assign taken_cnt     = taken_cnt_q;
    assign not_taken_cnt = not_taken_cnt_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: taken/not-taken, bad opcode, stall,
// ignored starts, mid-sequence reset and, with BRANCH_STATS_EN, counters.

module tb_branch_sequencer;

    localparam logic [4:0] BR_OP  = 5'b10010;
    localparam logic [4:0] BAD_OP = 5'b00011;

    logic        clk = 1'b0;
    logic        clr, start, hold, con_ff;
    logic [31:0] ir;
    logic        gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in;
    logic        zlo_out, pc_in, busy, done, taken, bad_op;
    logic [13:0] obs;

    int n_vec = 0;
    int n_err = 0;
    int cyc_cnt = 0;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, not_taken_cnt;
    logic [1:0]  taken_cnt2, not_taken_cnt2;
    logic gra2, r_out2, con_in2, pc_out2, y_in2, c_out2, alu_add2, z_in2;
    logic zlo_out2, pc_in2, busy2, done2, taken2, bad_op2;
`endif

    always #5 clk = ~clk;

    branch_sequencer #(.BR_OPCODE(BR_OP)) dut (
        .clk(clk), .clr(clr), .start(start), .hold(hold), .ir(ir), .con_ff(con_ff),
        .gra(gra), .r_out(r_out), .con_in(con_in), .pc_out(pc_out), .y_in(y_in),
        .c_out(c_out), .alu_add(alu_add), .z_in(z_in), .zlo_out(zlo_out),
        .pc_in(pc_in), .busy(busy), .done(done), .taken(taken), .bad_op(bad_op)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt)
`endif
    );

`ifdef BRANCH_STATS_EN
    branch_sequencer #(.BR_OPCODE(BR_OP), .CNT_W(2)) dut2 (
        .clk(clk), .clr(clr), .start(start), .hold(hold), .ir(ir), .con_ff(con_ff),
        .gra(gra2), .r_out(r_out2), .con_in(con_in2), .pc_out(pc_out2), .y_in(y_in2),
        .c_out(c_out2), .alu_add(alu_add2), .z_in(z_in2), .zlo_out(zlo_out2),
        .pc_in(pc_in2), .busy(busy2), .done(done2), .taken(taken2), .bad_op(bad_op2),
        .taken_cnt(taken_cnt2), .not_taken_cnt(not_taken_cnt2)
    );
`endif

    assign obs = {gra, r_out, con_in, pc_out, y_in, c_out, alu_add, z_in,
                  zlo_out, pc_in, busy, done, taken, bad_op};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc_cnt);
        end
    endtask

    // Expected output vector by state: 0 IDLE, 1 T3, 2 T4, 3 T5, 4 T6, 5 DONE.
    function automatic logic [13:0] exp_vec(input int st, input logic t, input logic h);
        logic [13:0] v;
        v = '0;
        case (st)
            1: v[13:11] = 3'b111;
            2: v[10:9]  = 2'b11;
            3: v[8:6]   = 3'b111;
            4: begin v[5] = 1'b1; v[4] = t; end
            default: ;
        endcase
        if (h) v = '0;
        v[3] = (st != 0);
        v[2] = (st == 5);
        v[1] = t;
        return v;
    endfunction

    task automatic cyc();
        @(posedge clk);
        cyc_cnt++;
        #1;
    endtask

    // One complete branch starting from an IDLE cycle.
    task automatic run_br(input logic con, input int nhold, input logic hold_at_accept,
                          input logic start_in_done);
        int n0;
        start = 1'b1;
        ir    = {BR_OP, 27'h0001234};
        hold  = hold_at_accept;
        cyc();
        n0 = cyc_cnt;
        hold   = 1'b0;
        con_ff = con;
        start  = 1'b1;
        ir     = {BAD_OP, 27'h0};
        #1 chk("t3", obs, exp_vec(1, 1'b0, 1'b0));
        cyc();
        start = 1'b0;
        ir    = {BR_OP, 27'h0001234};
        #1 chk("t4", obs, exp_vec(2, con, 1'b0));
        cyc();
        for (int i = 0; i < nhold; i++) begin
            hold   = 1'b1;
            con_ff = ~con;
            #1 chk("t5_hold", obs, exp_vec(3, con, 1'b1));
            cyc();
        end
        hold = 1'b0;
        #1 chk("t5", obs, exp_vec(3, con, 1'b0));
        cyc();
        #1 chk("t6", obs, exp_vec(4, con, 1'b0));
        chk("t6_pc_in", {31'b0, pc_in}, {31'b0, con});
        cyc();
        if (start_in_done) begin
            start = 1'b1;
            ir    = {BR_OP, 27'h0001234};
        end
        #1 chk("done", obs, exp_vec(5, con, 1'b0));
        chk("latency", cyc_cnt - n0, 32'(4 + nhold));
        cyc();
        start = 1'b0;
        #1 chk("idle_after", obs, exp_vec(0, con, 1'b0));
    endtask

    initial begin
        clr = 1'b1; start = 1'b0; hold = 1'b0; con_ff = 1'b0; ir = '0;
        cyc();
        cyc();
        #1 chk("reset", obs, 14'b0);
        clr = 1'b0;

        // Bad opcode: one-cycle bad_op, nothing else.
        start = 1'b1;
        ir    = {BAD_OP, 27'h0};
        #1 chk("bad_pre", obs, 14'b0);
        cyc();
        start = 1'b0;
        #1 chk("bad_op", obs, 14'b1);
        cyc();
        #1 chk("bad_clear", obs, 14'b0);

        run_br(1'b1, 0, 1'b0, 1'b0);   // brzr taken
        run_br(1'b0, 0, 1'b0, 1'b0);   // brnz not taken
        run_br(1'b1, 3, 1'b0, 1'b0);   // stall in T5, con_ff toggled
        run_br(1'b0, 0, 1'b1, 1'b1);   // hold at accept, start in DONE ignored

        // Reset mid-sequence in T4 with a taken decision already latched.
        start = 1'b1;
        ir    = {BR_OP, 27'h0};
        cyc();
        start  = 1'b0;
        con_ff = 1'b1;
        cyc();
        #1 chk("mid_t4", obs, exp_vec(2, 1'b1, 1'b0));
        clr = 1'b1;
        cyc();
        #1 chk("mid_reset", obs, 14'b0);
        clr = 1'b0;
        cyc();

        run_br(1'b1, 0, 1'b0, 1'b0);
        run_br(1'b1, 0, 1'b0, 1'b0);
        run_br(1'b0, 0, 1'b0, 1'b0);
        run_br(1'b1, 0, 1'b0, 1'b0);
        run_br(1'b0, 0, 1'b0, 1'b0);
`ifdef BRANCH_STATS_EN
        chk("taken_cnt", 32'(taken_cnt), 32'd3);
        chk("not_taken_cnt", 32'(not_taken_cnt), 32'd2);
        run_br(1'b1, 0, 1'b0, 1'b0);
        run_br(1'b1, 0, 1'b0, 1'b0);
        chk("taken_cnt_5", 32'(taken_cnt), 32'd5);
        chk("taken_cnt_sat", 32'(taken_cnt2), 32'd3);
        chk("not_taken_cnt_w2", 32'(not_taken_cnt2), 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
